clk_div_ctrl: RTL and testbench

- Programmable clock-divider controller.
- Accepts divide-ratio configuration through a valid/ready handshake and owns the divide counter.
- Applies every ratio change only at a period boundary, so clk_d never has runt pulses or truncated phases.
- Sits between the register/config logic and the divided-clock consumers; produces clk_d plus a one-cycle rise strobe for enable-style use in the clk domain.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_core.sv | 62 ++++++
 rtl/clk_div_ctrl.sv | 131 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared types, constants and helpers for the clock-divider
//            controller (state encoding, minimum legal ratio, legality check).
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

   // Controller states; 2-bit encoding kept explicit
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   // Smallest ratio that still yields one high and one low cycle
   localparam int MIN_DIV = 2;

   // A ratio is usable only if it produces both a high and a low phase
   function automatic logic div_legal(input logic [31:0] n);
      return (n >= 32'(MIN_DIV));
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_core
// Brief    : Divide counter with wrap detection and registered clk_d /
//            clk_d_rise decode. Counting restarts at zero whenever run
//            rises; the ratio is sampled continuously from div.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_core #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [CNT_W-1:0] div,
   output logic             wrap,
   output logic             clk_d,
   output logic             clk_d_rise
);

   logic             r_active;
   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_d;
   logic             r_clk_d_rise;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_half;

   // cnt never reaches 2**CNT_W-1 because the largest ratio wraps one short
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_half    = div >> 1;
   assign wrap      = r_active && (r_cnt == (div - 1'b1));

   assign clk_d      = r_clk_d;
   assign clk_d_rise = r_clk_d_rise;

   // Advance the counter and decode the next clk_d level from the next count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active     <= 1'b0;
         r_cnt        <= '0;
         r_clk_d      <= 1'b0;
         r_clk_d_rise <= 1'b0;
      end else if (!run) begin
         r_active     <= 1'b0;
         r_cnt        <= '0;
         r_clk_d      <= 1'b0;
         r_clk_d_rise <= 1'b0;
      end else if (!r_active || wrap) begin
         // Start of a period: high phase begins regardless of ratio
         r_active     <= 1'b1;
         r_cnt        <= '0;
         r_clk_d      <= 1'b1;
         r_clk_d_rise <= 1'b1;
      end else begin
         r_cnt        <= w_cnt_inc;
         r_clk_d      <= (w_cnt_inc < w_half);
         r_clk_d_rise <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Programmable clock-divider controller. Accepts ratios over a
//            valid/ready handshake and applies them only at period
//            boundaries so clk_d never shows runt or truncated phases.
//            Optional status outputs (cur_div, period_cnt) are built when
//            CLK_DIV_CTRL_STATUS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int RST_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_d,
   output logic             clk_d_rise,
   output logic             busy
`ifdef CLK_DIV_CTRL_STATUS_EN
   ,
   output logic [CNT_W-1:0] cur_div,
   output logic [15:0]      period_cnt
`endif
);

   localparam logic [CNT_W-1:0] C_RST_DIV = CNT_W'(RST_DIV);

   state_t           r_state;
   logic [CNT_W-1:0] r_div_q;
   logic [CNT_W-1:0] r_pend_div;
   logic             r_pend_q;
   logic             r_cfg_err;
   logic             r_busy;

   logic             w_xfer;
   logic             w_legal;
   logic             w_wrap;
   logic             w_to_idle;
   logic             w_run_next;
   logic             w_pend_next;

   // Only one ratio may be outstanding at a time
   assign cfg_ready = (r_state != ST_PEND) && !r_pend_q;
   assign w_xfer    = cfg_valid && cfg_ready;
   assign w_legal   = w_xfer && div_legal(32'(cfg_div));

   // Stopping completes only at the wrap, and only if enable is still low
   assign w_to_idle   = (r_state == ST_STOP) && w_wrap && !enable;
   assign w_run_next  = (r_state == ST_IDLE) ? enable : !w_to_idle;
   // A ratio accepted on the wrap cycle stays pending for one more period
   assign w_pend_next = (r_state != ST_IDLE) && !w_to_idle &&
                        (w_legal || (r_pend_q && !w_wrap));

   assign cfg_err = r_cfg_err;
   assign busy    = r_busy;

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .run        (w_run_next),
      .div        (r_div_q),
      .wrap       (w_wrap),
      .clk_d      (clk_d),
      .clk_d_rise (clk_d_rise)
   );

   // Controller FSM with ratio bookkeeping and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_div_q    <= C_RST_DIV;
         r_pend_div <= C_RST_DIV;
         r_pend_q   <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_cfg_err <= w_xfer && !w_legal;
         r_pend_q  <= w_pend_next;
         r_busy    <= w_run_next;

         if (w_legal && (r_state != ST_IDLE) && !w_to_idle) begin
            r_pend_div <= cfg_div;
         end

         // Ratio changes land on the wrap; when idle (or becoming idle) load directly
         if (w_wrap && r_pend_q) begin
            r_div_q <= r_pend_div;
         end else if (w_legal && ((r_state == ST_IDLE) || w_to_idle)) begin
            r_div_q <= cfg_div;
         end

         if (!w_run_next) begin
            r_state <= ST_IDLE;
         end else if (!enable) begin
            r_state <= ST_STOP;
         end else if (w_pend_next) begin
            r_state <= ST_PEND;
         end else begin
            r_state <= ST_RUN;
         end
      end
   end

`ifdef CLK_DIV_CTRL_STATUS_EN
   logic [15:0] r_period_cnt;

   assign cur_div    = r_div_q;
   assign period_cnt = r_period_cnt;

   // Count completed periods; the 16-bit counter rolls over naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period_cnt <= 16'd0;
      end else if (w_wrap) begin
         r_period_cnt <= r_period_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Self-checking bench for clk_div_ctrl. A period-level model
//            (position within period, active ratio, pending ratio) predicts
//            every output each cycle; literal patterns pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

   localparam int CNT_W   = 8;
   localparam int RST_DIV = 4;

   logic             clk       = 1'b0;
   logic             rst       = 1'b1;
   logic             enable    = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CNT_W-1:0] cfg_div   = '0;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_d;
   logic             clk_d_rise;
   logic             busy;
`ifdef CLK_DIV_CTRL_STATUS_EN
   logic [CNT_W-1:0] cur_div;
   logic [15:0]      period_cnt;
`endif

   clk_div_ctrl #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_div    (cfg_div),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .clk_d      (clk_d),
      .clk_d_rise (clk_d_rise),
      .busy       (busy)
`ifdef CLK_DIV_CTRL_STATUS_EN
      ,
      .cur_div    (cur_div),
      .period_cnt (period_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Period-level model: running flag, stop requested, position in period,
   // active ratio, pending ratio, error pulse and completed-period count
   bit m_run, m_stop, m_pend, m_err;
   int m_pos, m_n, m_pend_n, m_periods;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   task automatic model_reset();
      m_run = 0; m_stop = 0; m_pend = 0; m_err = 0;
      m_pos = 0; m_n = RST_DIV; m_pend_n = 0; m_periods = 0;
   endtask

   // Advance the model by one clk using the inputs seen at the edge
   task automatic model_step();
      bit xfer, legal, wrap;
      xfer  = cfg_valid && !m_pend;
      legal = xfer && (cfg_div >= 2);
      m_err = xfer && (cfg_div < 2);
      if (!m_run) begin
         if (legal) m_n = cfg_div;
         if (enable) begin
            m_run = 1; m_pos = 0; m_stop = 0;
         end
      end else begin
         wrap = (m_pos == m_n - 1);
         if (wrap) begin
            m_periods = (m_periods + 1) % 65536;
            if (m_pend) begin
               m_n = m_pend_n; m_pend = 0;
            end
            m_pos = 0;
         end else begin
            m_pos++;
         end
         if (wrap && m_stop && !enable) begin
            m_run = 0; m_stop = 0;
            if (legal) m_n = cfg_div;
         end else begin
            m_stop = !enable;
            if (legal) begin
               m_pend = 1; m_pend_n = cfg_div;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("clk_d",      clk_d,      32'(m_run && (m_pos < m_n / 2)));
      check("clk_d_rise", clk_d_rise, 32'(m_run && (m_pos == 0)));
      check("busy",       busy,       32'(m_run));
      check("cfg_ready",  cfg_ready,  32'(!m_pend));
      check("cfg_err",    cfg_err,    32'(m_err));
`ifdef CLK_DIV_CTRL_STATUS_EN
      check("cur_div",    cur_div,    32'(m_n));
      check("period_cnt", period_cnt, 32'(m_periods));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_all();
   endtask

   // exp bit i is the clk_d level required after tick i
   task automatic run_pattern(input string name, input int n, input logic [15:0] exp);
      for (int i = 0; i < n; i++) begin
         tick();
         check(name, clk_d, 32'(exp[i]));
      end
   endtask

   task automatic wait_pos(input int p, input string name);
      int k;
      k = 0;
      while (!(m_run && m_pos == p)) begin
         if (k == 600) begin
            timeout(name);
            break;
         end
         tick();
         k++;
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (m_run) begin
         if (k == 600) begin
            timeout(name);
            break;
         end
         tick();
         k++;
      end
   endtask

   task automatic wait_no_pend(input string name);
      int k;
      k = 0;
      while (m_pend) begin
         if (k == 600) begin
            timeout(name);
            break;
         end
         tick();
         k++;
      end
   endtask

   task automatic offer(input int n);
      cfg_valid = 1'b1;
      cfg_div   = CNT_W'(n);
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      // Reset state
      tick();
      tick();
      check("rst_ready", cfg_ready, 1);
      check("rst_busy",  busy,      0);
      check("rst_clk_d", clk_d,     0);
      rst = 1'b0;

      // Default ratio 4: 1,1,0,0 repeating
      enable = 1'b1;
      run_pattern("div4", 8, 16'h0033);
      check("div4_busy", busy, 1);

      // Change to 3 at cnt=1: current period stays 4, then 1,0,0
      wait_pos(1, "align_cnt1");
      offer(3);
      check("pend_ready", cfg_ready, 0);
      run_pattern("div4to3", 5, 16'h0012);
      check("ready_back", cfg_ready, 1);

      // Illegal ratios pulse cfg_err, period unchanged
      offer(1);
      check("err_div1", cfg_err, 1);
      offer(0);
      check("err_div0", cfg_err, 1);
      tick();
      check("err_clear", cfg_err, 0);
      run_pattern("div3_kept", 3, 16'h0004);

      // Ratio 5, stop requested at cnt=1
      offer(5);
      wait_no_pend("wait_div5");
      wait_pos(1, "align5_cnt1");
      enable = 1'b0;
      run_pattern("stop5", 7, 16'h0000);
      check("stop5_busy", busy, 0);

      // Stop withdrawn at cnt=3: no gap in the period
      enable = 1'b1;
      tick();
      wait_pos(1, "align5b_cnt1");
      enable = 1'b0;
      wait_pos(3, "align5b_cnt3");
      enable = 1'b1;
      run_pattern("no_gap", 7, 16'h0046);

      // Load 2 while idle, then run: toggles every cycle
      enable = 1'b0;
      wait_idle("idle_for_div2");
      offer(2);
      enable = 1'b1;
      run_pattern("div2", 4, 16'h0005);

      // Transfer on the wrap cycle applies one period later
      wait_pos(1, "wrap_align");
      offer(6);
      check("wrap_pend_ready", cfg_ready, 0);
      run_pattern("wrap_xfer", 5, 16'h000E);

      // enable falling together with a legal transfer: both honoured
      cfg_valid = 1'b1;
      cfg_div   = CNT_W'(3);
      enable    = 1'b0;
      tick();
      cfg_valid = 1'b0;
      wait_idle("stop_with_pend");
      check("stop_pend_busy",  busy,      0);
      check("stop_pend_ready", cfg_ready, 1);
      enable = 1'b1;
      run_pattern("after_stop", 3, 16'h0001);

      // Maximum ratio 255 for two full periods
      offer(255);
      wait_no_pend("wait_div255");
      for (int i = 0; i < 510; i++) tick();

      // Asynchronous reset while a ratio is pending
      wait_pos(0, "pend_align");
      offer(7);
      check("pre_rst_ready", cfg_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_clk_d", clk_d,      0);
      check("arst_rise",  clk_d_rise, 0);
      check("arst_busy",  busy,       0);
      check("arst_ready", cfg_ready,  1);
      check("arst_err",   cfg_err,    0);
`ifdef CLK_DIV_CTRL_STATUS_EN
      check("arst_period_cnt", period_cnt, 0);
      check("arst_cur_div",    cur_div,    RST_DIV);
`endif
      model_reset();
      tick();
      rst = 1'b0;
      run_pattern("post_rst", 8, 16'h0033);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
